// File: rtl/bht_update_queue.sv
// In-order queue of fetched branches with their predictions; each resolve pops the
// oldest entry and emits a registered predictor training update.
module bht_update_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PC_WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [PC_WIDTH-1:0]        push_pc_i,
    input  logic                       push_pred_valid_i,
    input  logic                       push_pred_taken_i,
    input  logic                       resolve_valid_i,
    input  logic                       resolve_taken_i,
    output logic                       update_valid_o,
    output logic [PC_WIDTH-1:0]        update_pc_o,
    output logic                       update_taken_o,
    output logic                       mispredict_o,
    output logic [31:0]                mispredict_cnt_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       resolve_error_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic                pred_valid;
        logic                pred_taken;
    } entry_t;

    entry_t              entries_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                update_valid_q, update_valid_d;
    logic [PC_WIDTH-1:0] update_pc_q, update_pc_d;
    logic                update_taken_q, update_taken_d;
    logic                mispredict_q, mispredict_d;
    logic [31:0]         mispredict_cnt_q, mispredict_cnt_d;
    logic                resolve_error_q, resolve_error_d;

    entry_t head;
    logic   push_ok;
    logic   pop_ok;
    logic   train;
    logic   head_mispred;

    assign head         = entries_q[rd_ptr_q];
    assign push_ready_o = (count_q != CNT_W'(DEPTH));
    assign push_ok      = push_valid_i && push_ready_o && !flush_i;
    // A push in the same cycle never feeds an empty-queue resolve.
    assign pop_ok       = resolve_valid_i && (count_q != '0) && !flush_i;
    assign train        = pop_ok && !debug_mode_i;
    assign head_mispred = head.pred_valid && (head.pred_taken != resolve_taken_i);

    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        update_valid_d   = train;
        update_pc_d      = update_pc_q;
        update_taken_d   = update_taken_q;
        mispredict_d     = train && head_mispred;
        mispredict_cnt_d = mispredict_cnt_q;
        resolve_error_d  = resolve_error_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d       = rd_ptr_q + PTR_W'(1);
                update_pc_d    = head.pc;
                update_taken_d = resolve_taken_i;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - CNT_W'(1);
            end
            if (resolve_valid_i && (count_q == '0)) begin
                resolve_error_d = 1'b1;
            end
        end

        if (train && head_mispred && (mispredict_cnt_q != '1)) begin
            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            update_valid_q   <= 1'b0;
            update_pc_q      <= '0;
            update_taken_q   <= 1'b0;
            mispredict_q     <= 1'b0;
            mispredict_cnt_q <= '0;
            resolve_error_q  <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            update_valid_q   <= update_valid_d;
            update_pc_q      <= update_pc_d;
            update_taken_q   <= update_taken_d;
            mispredict_q     <= mispredict_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            resolve_error_q  <= resolve_error_d;
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) begin
            entries_q[wr_ptr_q] <= '{pc: push_pc_i, pred_valid: push_pred_valid_i,
                                     pred_taken: push_pred_taken_i};
        end
    end

    assign update_valid_o   = update_valid_q;
    assign update_pc_o      = update_pc_q;
    assign update_taken_o   = update_taken_q;
    assign mispredict_o     = mispredict_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
    assign count_o          = count_q;
    assign resolve_error_o  = resolve_error_q;

endmodule

// File: doc/bht_update_queue.md
BHT_UPDATE_QUEUE -- requirements
Module: bht_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of in-flight branch entries; legal values are powers of two, 2..64.
REQ-002 SHALL have parameter PC_WIDTH, default 64, meaning the width of the branch PC.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: the reset, synchronous and active-high.
REQ-005 SHALL have port flush_i, input, 1 bit: discard all pending entries.
REQ-006 SHALL have port debug_mode_i, input, 1 bit: suppress predictor training while high.
REQ-007 SHALL have port push_valid_i, input, 1 bit: a fetched branch with its prediction is offered.
REQ-008 SHALL have port push_ready_o, output, 1 bit: the queue accepts a push this cycle.
REQ-009 SHALL have port push_pc_i, input, PC_WIDTH bits: the branch PC.
REQ-010 SHALL have port push_pred_valid_i, input, 1 bit: the predictor entry was valid at fetch.
REQ-011 SHALL have port push_pred_taken_i, input, 1 bit: the predicted direction.
REQ-012 SHALL have port resolve_valid_i, input, 1 bit: the oldest branch resolved this cycle, in program order.
REQ-013 SHALL have port resolve_taken_i, input, 1 bit: the actual direction.
REQ-014 SHALL have port update_valid_o, output, 1 bit: training update for the predictor.
REQ-015 SHALL have port update_pc_o, output, PC_WIDTH bits: the update PC.
REQ-016 SHALL have port update_taken_o, output, 1 bit: the update direction.
REQ-017 SHALL have port mispredict_o, output, 1 bit: the update was mispredicted; qualified by update_valid_o.
REQ-018 SHALL have port mispredict_cnt_o, output, 32 bits: the saturating mispredict count.
REQ-019 SHALL have port count_o, output, $clog2(DEPTH+1) bits: the current occupancy.
REQ-020 SHALL have port resolve_error_o, output, 1 bit: sticky flag for a resolve while the queue is empty.

Function
REQ-021 SHALL store entries {pc, pred_valid, pred_taken} in a circular buffer with wrapping read and write pointers, oldest entry at the read pointer.
REQ-022 SHALL drive push_ready_o = (count_o != DEPTH) from registered state only, with no combinational path from resolve_valid_i.
REQ-023 SHALL write an entry and advance the write pointer on push_valid_i && push_ready_o; when full, push_valid_i is ignored and no entry is overwritten.
REQ-024 SHALL pop the oldest entry on resolve_valid_i when count_o != 0, and register the outputs in the same edge: update_valid_o=1 (if debug_mode_i=0), update_pc_o=entry.pc, update_taken_o=resolve_taken_i; latency is one cycle from resolve to update.
REQ-025 SHALL compute mispredict_o = entry.pred_valid && (entry.pred_taken != resolve_taken_i); an entry with pred_valid=0 is never a mispredict.
REQ-026 SHALL hold update_valid_o at 0 and mispredict_o at 0 in every cycle without a qualifying pop.
REQ-027 SHALL still pop the oldest entry while debug_mode_i=1, but hold update_valid_o=0 and leave mispredict_cnt_o unchanged.
REQ-028 SHALL increment mispredict_cnt_o by 1 per qualifying mispredict, saturating at 0xFFFF_FFFF.
REQ-029 SHALL perform both a push and a pop in the same cycle when both qualify, leaving count_o unchanged.
REQ-030 SHALL, on resolve_valid_i while count_o == 0, ignore the resolve and set resolve_error_o, which stays set until reset; a same-cycle push does not bypass to the resolve.
REQ-031 SHALL, on flush_i, clear both pointers and count_o, ignore any same-cycle push and resolve, force update_valid_o=0 next cycle, and preserve mispredict_cnt_o and resolve_error_o.

Reset
REQ-032 SHALL, with rst_i high at a rising edge, clear the pointers, count_o, update_valid_o, update_pc_o, update_taken_o, mispredict_o, mispredict_cnt_o and resolve_error_o to 0, and then show push_ready_o=1.
REQ-033 SHALL give rst_i priority over flush_i, push and resolve; entry payload storage is not reset.

Verification
REQ-034 SHALL cover: push pc=0x80 with pred_valid=1, pred_taken=1, then resolve taken=0 -> next cycle update_valid_o=1, update_pc_o=0x80, update_taken_o=0, mispredict_o=1, mispredict_cnt_o=1.
REQ-035 SHALL cover: 8 pushes with DEPTH=8 -> count_o=8, push_ready_o=0; a 9th push is dropped; 8 resolves return the PCs in push order across pointer wrap.
REQ-036 SHALL cover: full queue with push and resolve in the same cycle -> the push is dropped and count_o=7; with count_o=3, push and resolve together -> count_o stays 3.
REQ-037 SHALL cover: resolve while empty -> resolve_error_o=1 sticky and update_valid_o=0; flush with count_o=5 -> count_o=0 and the counter is unchanged.
REQ-038 SHALL cover: debug_mode_i=1 during a mispredicted resolve -> update_valid_o=0, count_o decremented, mispredict_cnt_o unchanged; mispredict_cnt_o preloaded to 0xFFFF_FFFF plus a mispredict -> stays 0xFFFF_FFFF.
